// File: rtl/panda_data_mem_if.sv
// Panda data bus: req/gnt/rvalid handshake between a load-store unit (master)
// and a memory responder (slave).
interface panda_data_mem_if;
  logic        req;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/panda_data_mem_responder.sv
// Word-addressed RAM behind the Panda data bus: one outstanding transaction,
// byte-enable stores, response after WaitStates extra cycles.
module panda_data_mem_responder #(
  parameter int          Depth      = 1024,
  parameter int          WaitStates = 1,
  parameter logic [31:0] BaseAddr   = 32'h0000_0000,
  parameter string       InitFile   = ""
) (
  input logic             clk_i,
  input logic             rst_i,
  panda_data_mem_if.slave bus
);
  // state | meaning
  // IDLE  | grant follows req; a handshake captures the response
  // WAIT  | counting down wait states, no grant
  // RESP  | rvalid for one cycle, then back to IDLE
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam int          AW      = $clog2(Depth);
  localparam logic [32:0] Span    = 33'(Depth) << 2;
  localparam logic [2:0]  CntInit = (WaitStates > 0) ? 3'(WaitStates - 1) : 3'd0;

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] mem [Depth];

  logic [32:0]   offset;
  logic          addr_err;
  logic [AW-1:0] idx;
  logic          accept;
  logic          is_store;

  // Bit 32 of the offset is the borrow, flagging addresses below BaseAddr.
  assign offset   = {1'b0, bus.addr} - {1'b0, BaseAddr};
  assign addr_err = (bus.addr[1:0] != 2'b00) || offset[32] || (offset >= Span);
  assign idx      = offset[AW+1:2];
  assign is_store = |bus.we;

  assign accept     = (state == ST_IDLE) && bus.req && !rst_i;
  assign bus.gnt    = accept;
  assign bus.rvalid = (state == ST_RESP) && !rst_i;
  assign bus.rdata  = bus.rvalid ? resp_data : 32'h0;
  assign bus.err    = bus.rvalid && resp_err;

  // RAM has no reset; stores commit at the acceptance edge.
  always_ff @(posedge clk_i) begin
    if (accept && is_store && !addr_err) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.we[k]) mem[idx][8*k +: 8] <= bus.wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      resp_data <= 32'h0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            resp_err  <= addr_err;
            resp_data <= (!is_store && !addr_err) ? mem[idx] : 32'h0;
            cnt       <= CntInit;
            state     <= (WaitStates > 0) ? ST_WAIT : ST_RESP;
          end
        end
        ST_WAIT: begin
          if (cnt == 3'd0) state <= ST_RESP;
          else             cnt   <= cnt - 3'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
